ycr_dmem_router: RTL
====================

Name: ycr_dmem_router

Overview:
- Sits directly upstream of the TCM data port, between the core data-memory interface and its targets.
- Decodes each core dmem request and forwards it to the TCM data port or to the external data port (the system-bus bridge).
- Tracks outstanding requests in an in-order port-ID FIFO, so each response is returned to the core from the correct target.
- Adds zero cycles of latency on both the request and response paths.

Parameters:
- YCR_TCM_ADDR_MASK, 32'hFFFF_0000, address bits compared for the TCM window.
- YCR_TCM_ADDR_PATTERN, 32'h0C48_0000, value the masked address must equal to select the TCM.
- YCR_EXT_ADDR_MASK, 32'hF000_0000, external-window mask (used only with the optional feature).
- YCR_EXT_ADDR_PATTERN, 32'h0000_0000, external-window pattern (used only with the optional feature).
- YCR_OUTSTD, 2, depth of the outstanding-request FIFO; allowed range 1..4.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; synchronous, active-low.
- dmem_req_ack  out  1  request accepted this cycle.
- dmem_req  in  1  core request valid.
- dmem_cmd  in  1  command, YCR_MEM_CMD_RD or YCR_MEM_CMD_WR.
- dmem_width  in  2  access width: byte, halfword or word.
- dmem_addr  in  `YCR_DMEM_AWIDTH  byte address.
- dmem_wdata  in  `YCR_DMEM_DWIDTH  write data.
- dmem_rdata  out  `YCR_DMEM_DWIDTH  read data.
- dmem_resp  out  2  response: NOTRDY, RDY_OK or RDY_ER.
- tcm_req_ack  in  1  TCM accepted the request.
- tcm_req, tcm_cmd, tcm_width, tcm_addr, tcm_wdata  out  (widths as dmem_*)  request to the TCM data port.
- tcm_rdata  in  `YCR_DMEM_DWIDTH  TCM read data.
- tcm_resp  in  2  TCM response.
- ext_req_ack  in  1  external port accepted the request.
- ext_req, ext_cmd, ext_width, ext_addr, ext_wdata  out  (widths as dmem_*)  request to the external port.
- ext_rdata  in  `YCR_DMEM_DWIDTH  external read data.
- ext_resp  in  2  external response.

Behaviour:
- Request handshake: a transfer occurs when req & req_ack are both high in the same cycle.
- Response handshake: a response is complete in the cycle where resp != NOTRDY.
- Target select: sel = TCM if (dmem_addr & YCR_TCM_ADDR_MASK) == YCR_TCM_ADDR_PATTERN, otherwise EXT.
- Forwarding: cmd, width, addr and wdata go to both ports unchanged and combinationally.
- Request strobes: tcm_req = dmem_req & sel==TCM & can_issue; ext_req uses sel==EXT in the same way.
- can_issue = !full & (count==0 | head_port==sel). Count is the registered count at the start of the cycle. A response popped in the same cycle does not enable a port switch, so there is no resp-to-ack combinational path.
- dmem_req_ack = can_issue & selected port's req_ack.
- Port-ID FIFO: YCR_OUTSTD entries, each holding a port ID.
  - Push on dmem_req & dmem_req_ack.
  - Pop when the head port's resp != NOTRDY.
  - Simultaneous push and pop leaves count unchanged.
  - Read and write pointers wrap modulo YCR_OUTSTD.
- Response: when count>0, dmem_resp/dmem_rdata = head port's resp/rdata combinationally; otherwise dmem_resp = NOTRDY and dmem_rdata = 0.
- A response from a non-head port is ignored. This is a protocol violation and is flagged by an assertion.
- Full: dmem_req_ack = 0; the request is held off.
- Empty: no pop is possible.
- Reset (synchronous, active-low): count = 0 and both pointers = 0.
  - Outputs after reset: dmem_resp = NOTRDY, dmem_rdata = 0, tcm_req = ext_req = 0 until dmem_req is asserted.
  - Reset mid-operation drops all outstanding entries; late target responses are ignored because count = 0.
- Latency: the request path is combinational. A TCM access therefore gives dmem_resp = RDY_OK one cycle after acceptance, unchanged from the TCM's own timing.
- Back-to-back: a single-cycle target (TCM) sustains one accepted request per cycle.

Optional Feature:
- Macro: YCR_DMEM_ROUTER_ERR_EN.
- Defined: an address matching neither the TCM window nor (addr & YCR_EXT_ADDR_MASK) == YCR_EXT_ADDR_PATTERN selects an internal ERR port.
  - ERR port: req_ack is always 1 and no external strobe is driven.
  - Its response is RDY_ER with rdata 0, in the cycle after acceptance, delivered in FIFO order.
  - Port ID widens to 2 bits.
- Undefined: every non-TCM address goes to EXT; the ERR port logic is absent.

Test Plan:
- Single TCM read: read at 0x0C48_0010, tcm_rdata = 0xDEADBEEF -> tcm_req=1 and dmem_req_ack=1 in cycle 0; dmem_resp=RDY_OK with rdata 0xDEADBEEF in cycle 1; ext_req stays 0.
- Port switch stall: EXT write to 0x2000_0000, ext_resp held NOTRDY for 3 cycles, then a TCM read -> the TCM request is not acked until the cycle after ext_resp=RDY_OK.
- FIFO full: YCR_OUTSTD=2, three back-to-back EXT reads with ext_req_ack=1 and no ext_resp -> third request ack=0; it is accepted the cycle after the first response pops.
- Simultaneous push and pop: streaming TCM reads to 0x0C48_0000, 0x0C48_0004, 0x0C48_0008 -> one accept per cycle, count stays 1, responses return in order.
- Reset mid-operation: rst_n low for 1 cycle with 2 EXT entries outstanding -> dmem_resp=NOTRDY afterwards; a later ext_resp=RDY_OK does not reach the core.
- Error decode (YCR_DMEM_ROUTER_ERR_EN, EXT window 0x0XXX_XXXX): read at 0x3000_0000 -> no tcm_req and no ext_req; dmem_resp=RDY_ER with dmem_rdata=0 one cycle later.

Source files
------------

// File: rtl/ycr_dmem_router.sv
// ---------------------------------------------------------------------------
// ycr_dmem_router
//
// Purpose:
//   Routes core data-memory requests to either the TCM data port or the
//   external (system-bus bridge) data port, based on the request address.
//   An in-order FIFO of port IDs records which target owns each outstanding
//   request, so every response is returned to the core from the correct
//   target. Both the request and response paths are purely combinational,
//   so the router adds no latency.
//
// Optional feature (macro YCR_DMEM_ROUTER_ERR_EN):
//   When defined, an address outside both the TCM and the external windows
//   goes to an internal ERR port. That port always accepts and answers
//   RDY_ER with zero read data once its entry reaches the FIFO head.
//   When undefined, every non-TCM address goes to the external port.
//
// Ports:
//   clk, rst_n                 core clock, synchronous active-low reset
//   dmem_*                     core-side request / response
//   tcm_*                      TCM data port request / response
//   ext_*                      external data port request / response
// ---------------------------------------------------------------------------

`ifndef YCR_DMEM_AWIDTH
`define YCR_DMEM_AWIDTH 32
`endif
`ifndef YCR_DMEM_DWIDTH
`define YCR_DMEM_DWIDTH 32
`endif

module ycr_dmem_router #(
    parameter logic [`YCR_DMEM_AWIDTH-1:0] YCR_TCM_ADDR_MASK    = 32'hFFFF_0000,
    parameter logic [`YCR_DMEM_AWIDTH-1:0] YCR_TCM_ADDR_PATTERN = 32'h0C48_0000,
    parameter logic [`YCR_DMEM_AWIDTH-1:0] YCR_EXT_ADDR_MASK    = 32'hF000_0000,
    parameter logic [`YCR_DMEM_AWIDTH-1:0] YCR_EXT_ADDR_PATTERN = 32'h0000_0000,
    parameter int unsigned                 YCR_OUTSTD           = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,

    // core side
    output logic                         dmem_req_ack,
    input  logic                         dmem_req,
    input  logic                         dmem_cmd,
    input  logic [1:0]                   dmem_width,
    input  logic [`YCR_DMEM_AWIDTH-1:0]  dmem_addr,
    input  logic [`YCR_DMEM_DWIDTH-1:0]  dmem_wdata,
    output logic [`YCR_DMEM_DWIDTH-1:0]  dmem_rdata,
    output logic [1:0]                   dmem_resp,

    // TCM data port
    input  logic                         tcm_req_ack,
    output logic                         tcm_req,
    output logic                         tcm_cmd,
    output logic [1:0]                   tcm_width,
    output logic [`YCR_DMEM_AWIDTH-1:0]  tcm_addr,
    output logic [`YCR_DMEM_DWIDTH-1:0]  tcm_wdata,
    input  logic [`YCR_DMEM_DWIDTH-1:0]  tcm_rdata,
    input  logic [1:0]                   tcm_resp,

    // external data port
    input  logic                         ext_req_ack,
    output logic                         ext_req,
    output logic                         ext_cmd,
    output logic [1:0]                   ext_width,
    output logic [`YCR_DMEM_AWIDTH-1:0]  ext_addr,
    output logic [`YCR_DMEM_DWIDTH-1:0]  ext_wdata,
    input  logic [`YCR_DMEM_DWIDTH-1:0]  ext_rdata,
    input  logic [1:0]                   ext_resp
);

    // Response encodings
    localparam logic [1:0] YCR_MEM_RESP_NOTRDY = 2'd0;
    localparam logic [1:0] YCR_MEM_RESP_RDY_OK = 2'd1;
    localparam logic [1:0] YCR_MEM_RESP_RDY_ER = 2'd2;

    // Pointers cover the largest allowed depth; storage is always 4 entries
    // so a 2-bit pointer indexes it exactly for every legal YCR_OUTSTD.
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 3;

    if (YCR_OUTSTD < 1 || YCR_OUTSTD > 4) begin : g_bad_outstd
        $error("ycr_dmem_router: YCR_OUTSTD must be within 1..4");
    end

`ifdef YCR_DMEM_ROUTER_ERR_EN
    typedef enum logic [1:0] {
        PORT_TCM = 2'd0,
        PORT_EXT = 2'd1,
        PORT_ERR = 2'd2
    } port_e;
`else
    typedef enum logic {
        PORT_TCM = 1'b0,
        PORT_EXT = 1'b1
    } port_e;
`endif

    // State
    port_e              fifo_q [0:3];
    port_e              fifo_d [0:3];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    // Decode / control
    logic                         tcm_hit;
    logic                         ext_hit;
    port_e                        sel;
    port_e                        head;
    logic                         full;
    logic                         can_issue;
    logic                         sel_ack;
    logic [1:0]                   head_resp;
    logic [`YCR_DMEM_DWIDTH-1:0]  head_rdata;
    logic                         push;
    logic                         pop;
    logic                         unused_ext_hit;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(YCR_OUTSTD - 1)) ? '0 : p + 1'b1;
    endfunction

    assign tcm_hit        = (dmem_addr & YCR_TCM_ADDR_MASK) == YCR_TCM_ADDR_PATTERN;
    assign ext_hit        = (dmem_addr & YCR_EXT_ADDR_MASK) == YCR_EXT_ADDR_PATTERN;
    assign unused_ext_hit = ext_hit;

    // Request forwarding: payload goes to both ports unchanged.
    assign tcm_cmd   = dmem_cmd;
    assign tcm_width = dmem_width;
    assign tcm_addr  = dmem_addr;
    assign tcm_wdata = dmem_wdata;
    assign ext_cmd   = dmem_cmd;
    assign ext_width = dmem_width;
    assign ext_addr  = dmem_addr;
    assign ext_wdata = dmem_wdata;

    always_comb begin
        // Target select
        sel = tcm_hit ? PORT_TCM : PORT_EXT;
`ifdef YCR_DMEM_ROUTER_ERR_EN
        if (!tcm_hit && !ext_hit) begin
            sel = PORT_ERR;
        end
`endif

        head = fifo_q[rd_ptr_q];
        full = (count_q == CNT_W'(YCR_OUTSTD));

        // Issue decision uses only registered state, so a response popping
        // this cycle never feeds back into dmem_req_ack.
        can_issue = !full && ((count_q == '0) || (head == sel));

        sel_ack = (sel == PORT_TCM) ? tcm_req_ack : ext_req_ack;
`ifdef YCR_DMEM_ROUTER_ERR_EN
        if (sel == PORT_ERR) begin
            sel_ack = 1'b1;
        end
`endif

        tcm_req      = dmem_req && (sel == PORT_TCM) && can_issue;
        ext_req      = dmem_req && (sel == PORT_EXT) && can_issue;
        dmem_req_ack = can_issue && sel_ack;

        // Head-port response mux
        head_resp  = (head == PORT_TCM) ? tcm_resp  : ext_resp;
        head_rdata = (head == PORT_TCM) ? tcm_rdata : ext_rdata;
`ifdef YCR_DMEM_ROUTER_ERR_EN
        // The ERR entry becomes head no earlier than the cycle after
        // acceptance, which gives its one-cycle response timing for free.
        if (head == PORT_ERR) begin
            head_resp  = YCR_MEM_RESP_RDY_ER;
            head_rdata = '0;
        end
`endif

        if (count_q != '0) begin
            dmem_resp  = head_resp;
            dmem_rdata = head_rdata;
        end else begin
            dmem_resp  = YCR_MEM_RESP_NOTRDY;
            dmem_rdata = '0;
        end

        push = dmem_req && dmem_req_ack;
        pop  = (count_q != '0) && (head_resp != YCR_MEM_RESP_NOTRDY);

        // Next-state
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                fifo_q[i] <= PORT_TCM;
            end
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            for (int unsigned i = 0; i < 4; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

`ifndef SYNTHESIS
    // A target that is not at the FIFO head must not respond while
    // requests are outstanding; such a response would be silently dropped.
    logic nonhead_resp;
    assign nonhead_resp = ((head != PORT_TCM) && (tcm_resp != YCR_MEM_RESP_NOTRDY)) ||
                          ((head != PORT_EXT) && (ext_resp != YCR_MEM_RESP_NOTRDY));

    always_ff @(posedge clk) begin
        if (rst_n && (count_q != '0)) begin
            assert (!nonhead_resp);
        end
    end

    logic unused_rdy_ok;
    assign unused_rdy_ok = YCR_MEM_RESP_RDY_OK[0] ^ YCR_MEM_RESP_RDY_ER[0];
`endif

endmodule
